// File: rtl/bsg_link_pkg.sv
// Shared link constants and payload types for the BSG off-chip link (upstream and downstream).
package bsg_link_pkg;

  localparam int unsigned CH_WIDTH   = 8;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned CORE_WIDTH = 64;
  localparam int unsigned BEAT_WIDTH = NUM_CH * CH_WIDTH;
  // CORE_WIDTH must be an exact multiple of BEAT_WIDTH.
  localparam int unsigned BEATS      = CORE_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_WIDTH  = 7;
  localparam int unsigned TOKEN_W    = $clog2(FIFO_DEPTH + 1);

  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [CORE_WIDTH-1:0] word_t;

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// Small register-based FIFO holding completed link words until the core consumes them.
module bsg_link_rx_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  // Pop only a valid head; push when space exists or a pop frees a slot this cycle.
  always_comb begin
    w_do_pop  = pop & ~empty;
    w_do_push = push & (~full | w_do_pop);
  end

  // Storage, pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/bsg_downstream_in.sv
// Receive side of the BSG link: deserializes beats into words, buffers them, returns credits.
module bsg_downstream_in
  import bsg_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 io_valid_in,
  input  logic [CH_WIDTH-1:0]  io_data_in_ch0,
  input  logic [CH_WIDTH-1:0]  io_data_in_ch1,
  output logic                 io_token_out,
  output logic                 core_valid_out,
  output word_t                core_data_out,
  input  logic                 core_yumi_in,
  output logic [CNT_WIDTH-1:0] rx_cnt,
  output logic                 overflow_err
);

  logic [BEAT_IDX_W-1:0] r_beat_idx;
  word_t                 r_asm;
  logic [TOKEN_W-1:0]    r_pending;
  logic                  r_token_out;
  logic [CNT_WIDTH-1:0]  r_rx_cnt;
  logic                  r_overflow;

  beat_t w_beat;
  word_t w_word;
  word_t w_head;
  logic  w_last;
  logic  w_full;
  logic  w_empty;
  logic  w_deq;
  logic  w_push;
  logic  w_drop;
  logic  w_tok_fire;

  // Merge the current beat into the assembly word and derive push/dequeue/credit controls.
  always_comb begin
    w_beat = {io_data_in_ch1, io_data_in_ch0};
    w_word = r_asm;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (r_beat_idx == BEAT_IDX_W'(k)) w_word[k*BEAT_WIDTH +: BEAT_WIDTH] = w_beat;
    end
    w_last     = io_valid_in & (r_beat_idx == BEAT_IDX_W'(BEATS - 1));
    w_deq      = core_yumi_in & ~w_empty;
    w_push     = w_last & (~w_full | w_deq);
    w_drop     = w_last & w_full & ~w_deq;
    // A dequeue is credited on the very next cycle; any backlog drains one per cycle.
    w_tok_fire = (r_pending != '0) | w_deq;
  end

  // Deserializer: beat index and partially assembled word; idle cycles hold both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_idx <= '0;
      r_asm      <= '0;
    end else if (io_valid_in) begin
      r_asm      <= w_word;
      r_beat_idx <= w_last ? '0 : r_beat_idx + BEAT_IDX_W'(1);
    end
  end

  // Credit return, accepted-word counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_token_out <= 1'b0;
      r_rx_cnt    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pending   <= r_pending + TOKEN_W'(w_deq) - TOKEN_W'(w_tok_fire);
      r_token_out <= w_tok_fire;
      if (w_push) r_rx_cnt <= r_rx_cnt + CNT_WIDTH'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Outstanding credits can never exceed the FIFO depth.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_deq && (r_pending == TOKEN_W'(FIFO_DEPTH))));
  end

  bsg_link_rx_fifo #(
    .WIDTH (CORE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_word),
    .pop       (w_deq),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign io_token_out   = r_token_out;
  assign core_valid_out = ~w_empty;
  assign core_data_out  = w_head;
  assign rx_cnt         = r_rx_cnt;
  assign overflow_err   = r_overflow;

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Scoreboard bench for bsg_downstream_in: expected words queued on send, compared on consume.
module tb_bsg_downstream_in;
  import bsg_link_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 io_valid_in;
  logic [CH_WIDTH-1:0]  io_data_in_ch0;
  logic [CH_WIDTH-1:0]  io_data_in_ch1;
  logic                 io_token_out;
  logic                 core_valid_out;
  word_t                core_data_out;
  logic                 core_yumi_in;
  logic [CNT_WIDTH-1:0] rx_cnt;
  logic                 overflow_err;

  int    n_total = 0;
  int    n_bad   = 0;
  word_t sb[$];
  int    m_cnt;
  int    m_rx;
  logic  m_ovf;

  bsg_downstream_in dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_valid_in    (io_valid_in),
    .io_data_in_ch0 (io_data_in_ch0),
    .io_data_in_ch1 (io_data_in_ch1),
    .io_token_out   (io_token_out),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .core_yumi_in   (core_yumi_in),
    .rx_cnt         (rx_cnt),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io_valid_in = 1'b1;
    io_data_in_ch0 = 8'hA5;
    io_data_in_ch1 = 8'h5A;
    core_yumi_in = 1'b1;
    tick();
    tick();
    io_valid_in = 1'b0;
    core_yumi_in = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    m_cnt = 0;
    m_rx = 0;
    m_ovf = 1'b0;
  endtask

  // Drive one word as BEATS beats with 'gap' idle cycles after each; optional yumi on last beat.
  task automatic send_word(input word_t w, input int gap, input logic yumi_last);
    logic deq;
    logic acc;
    for (int k = 0; k < int'(BEATS); k++) begin
      io_valid_in = 1'b1;
      io_data_in_ch0 = w[k*BEAT_WIDTH +: CH_WIDTH];
      io_data_in_ch1 = w[k*BEAT_WIDTH + CH_WIDTH +: CH_WIDTH];
      deq = 1'b0;
      if (k == int'(BEATS) - 1) begin
        core_yumi_in = yumi_last;
        deq = yumi_last && (m_cnt > 0);
        if (deq) begin
          n_total++;
          if (sb.size() == 0 || core_data_out !== sb[0]) begin
            n_bad++;
            $display("FAIL deq_head: got %h want %h", core_data_out, (sb.size() != 0) ? sb[0] : '0);
          end
          if (sb.size() != 0) void'(sb.pop_front());
        end
        acc = (m_cnt < int'(FIFO_DEPTH)) || deq;
        if (acc) begin
          sb.push_back(w);
          m_rx++;
        end else begin
          m_ovf = 1'b1;
        end
        m_cnt = m_cnt - int'(deq) + int'(acc);
      end
      tick();
      io_valid_in = 1'b0;
      core_yumi_in = 1'b0;
      if (k == int'(BEATS) - 1) begin
        n_total++;
        if (io_token_out !== deq) begin
          n_bad++;
          $display("FAIL token_after_word: got %b want %b", io_token_out, deq);
        end
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        n_total++;
        if (core_valid_out !== (m_cnt > 0)) begin
          n_bad++;
          $display("FAIL gap_valid: got %b want %b", core_valid_out, (m_cnt > 0));
        end
      end
    end
  endtask

  // Consume the head for one cycle and check its credit pulse.
  task automatic pop_one();
    core_yumi_in = 1'b1;
    n_total++;
    if (core_valid_out !== 1'b1 || sb.size() == 0 || core_data_out !== sb[0]) begin
      n_bad++;
      $display("FAIL pop_head: valid %b got %h want %h", core_valid_out, core_data_out,
               (sb.size() != 0) ? sb[0] : '0);
    end
    if (sb.size() != 0) void'(sb.pop_front());
    m_cnt--;
    tick();
    core_yumi_in = 1'b0;
    n_total++;
    if (io_token_out !== 1'b1) begin
      n_bad++;
      $display("FAIL pop_token: got %b want 1", io_token_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({io_token_out, core_valid_out, overflow_err} !== 3'b000 || core_data_out !== '0 || rx_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: tok %b vld %b ovf %b data %h rx %0d want all 0",
               io_token_out, core_valid_out, overflow_err, core_data_out, rx_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_word(64'h7766554433221100, 0, 1'b0);
    n_total++;
    if (core_valid_out !== 1'b1 || core_data_out !== 64'h7766554433221100 || rx_cnt !== CNT_WIDTH'(1)) begin
      n_bad++;
      $display("FAIL basic_word: vld %b data %h rx %0d want 1 7766554433221100 1",
               core_valid_out, core_data_out, rx_cnt);
    end
    n_total++;
    if (core_data_out !== sb[0]) begin
      n_bad++;
      $display("FAIL basic_sb: got %h want %h", core_data_out, sb[0]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_word(64'h7766554433221100, 2, 1'b0);
    n_total++;
    if (core_valid_out !== 1'b1 || core_data_out !== sb[0] || rx_cnt !== CNT_WIDTH'(m_rx)) begin
      n_bad++;
      $display("FAIL gaps_word: vld %b data %h rx %0d want 1 %h %0d",
               core_valid_out, core_data_out, rx_cnt, sb[0], m_rx);
    end
  endtask

  task automatic test_overflow();
    word_t w1;
    do_reset();
    w1 = {$urandom(), $urandom()};
    send_word(w1, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_word({$urandom(), $urandom()}, 1, 1'b0);
    n_total++;
    if (overflow_err !== 1'b0 || rx_cnt !== CNT_WIDTH'(4)) begin
      n_bad++;
      $display("FAIL ovf_pre: ovf %b rx %0d want 0 4", overflow_err, rx_cnt);
    end
    send_word({$urandom(), $urandom()}, 0, 1'b0);
    n_total++;
    if (overflow_err !== 1'b1 || m_ovf !== 1'b1 || rx_cnt !== CNT_WIDTH'(4) || core_data_out !== w1) begin
      n_bad++;
      $display("FAIL ovf_drop: ovf %b rx %0d head %h want 1 4 %h", overflow_err, rx_cnt, core_data_out, w1);
    end
    while (m_cnt > 0) pop_one();
    tick();
    n_total++;
    if (core_valid_out !== 1'b0 || overflow_err !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_drain: vld %b ovf %b want 0 1", core_valid_out, overflow_err);
    end
  endtask

  task automatic test_full_deq();
    do_reset();
    for (int i = 0; i < 4; i++) send_word({$urandom(), $urandom()}, 0, 1'b0);
    send_word({$urandom(), $urandom()}, 0, 1'b1);
    n_total++;
    if (overflow_err !== 1'b0 || rx_cnt !== CNT_WIDTH'(5) || core_data_out !== sb[0]) begin
      n_bad++;
      $display("FAIL fulldeq: ovf %b rx %0d head %h want 0 5 %h", overflow_err, rx_cnt, core_data_out, sb[0]);
    end
    tick();
    n_total++;
    if (io_token_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fulldeq_single_pulse: got %b want 0", io_token_out);
    end
    while (m_cnt > 0) pop_one();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) send_word({$urandom(), $urandom()}, 0, 1'b0);
    core_yumi_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (core_valid_out !== 1'b1 || core_data_out !== sb[0]) begin
        n_bad++;
        $display("FAIL b2b_head%0d: vld %b got %h want %h", i, core_valid_out, core_data_out, sb[0]);
      end
      void'(sb.pop_front());
      m_cnt--;
      tick();
      n_total++;
      if (io_token_out !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_token%0d: got %b want 1", i, io_token_out);
      end
    end
    n_total++;
    if (core_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_empty: vld %b want 0", core_valid_out);
    end
    tick();
    core_yumi_in = 1'b0;
    n_total++;
    if (io_token_out !== 1'b0 || rx_cnt !== CNT_WIDTH'(3)) begin
      n_bad++;
      $display("FAIL b2b_idle_yumi: tok %b rx %0d want 0 3", io_token_out, rx_cnt);
    end
  endtask

  task automatic test_reset_partial();
    word_t fresh;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      io_valid_in = 1'b1;
      io_data_in_ch0 = 8'hEE;
      io_data_in_ch1 = 8'hDD;
      tick();
    end
    rst_n = 1'b0;
    tick();
    n_total++;
    if ({io_token_out, core_valid_out, overflow_err} !== 3'b000 || core_data_out !== '0 || rx_cnt !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: tok %b vld %b ovf %b data %h rx %0d want all 0",
               io_token_out, core_valid_out, overflow_err, core_data_out, rx_cnt);
    end
    io_valid_in = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    m_cnt = 0;
    m_rx = 0;
    m_ovf = 1'b0;
    tick();
    fresh = 64'h0123456789ABCDEF;
    send_word(fresh, 0, 1'b0);
    n_total++;
    if (core_valid_out !== 1'b1 || core_data_out !== fresh || rx_cnt !== CNT_WIDTH'(1)) begin
      n_bad++;
      $display("FAIL midreset_fresh: vld %b data %h rx %0d want 1 %h 1", core_valid_out, core_data_out, rx_cnt, fresh);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    io_valid_in = 1'b0;
    io_data_in_ch0 = '0;
    io_data_in_ch1 = '0;
    core_yumi_in = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_full_deq();
    test_back_to_back();
    test_reset_partial();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
